alu_operand_sequencer: RTL

- Upstream feeder for the 4-bit subtractor in the ALU datapath.
- Collects operand A, then operand B, from a shared nibble bus using a valid/ready handshake.
- Optionally swaps the pair so that minuend >= subtrahend.
- Presents the pair, borrow-in and swap flag to the subtractor stage through a one-entry registered valid/ready output, and counts issued pairs.

---
 rtl/alu_operand_sequencer_if.sv | 35 +++
 rtl/alu_operand_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer_if
// Function : Operand bus and subtractor-side handshake of the sequencer.
// Revision : 1.0
// ============================================================================
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bin_in;
    logic             swap_en;
    logic             clear;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_bin;
    logic             op_swapped;
    logic             op_valid;
    logic             op_ready;
    logic [CNT_W-1:0] op_count;

    modport master (
        output din, din_valid, bin_in, swap_en, clear, op_ready,
        input  din_ready, op_a, op_b, op_bin, op_swapped, op_valid, op_count
    );

    modport slave (
        input  din, din_valid, bin_in, swap_en, clear, op_ready,
        output din_ready, op_a, op_b, op_bin, op_swapped, op_valid, op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer
// Function : Collects A then B, optionally orders them, issues pair downstream.
// Revision : 1.0
// ============================================================================
module alu_operand_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    alu_operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_bin_q, op_bin_d;
    logic             op_swapped_q, op_swapped_d;
    logic             op_valid_q, op_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic din_ready;
    logic in_xfer;
    logic out_xfer;
    logic do_swap;

    // While a pair is held, a new operand may only enter as the pair leaves.
    assign din_ready = (state_q == S_OUT) ? bus.op_ready : 1'b1;
    assign in_xfer   = bus.din_valid & din_ready;
    assign out_xfer  = op_valid_q & bus.op_ready;
    assign do_swap   = bus.swap_en & (a_q < bus.din);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_bin_d     = op_bin_q;
        op_swapped_d = op_swapped_q;
        op_valid_d   = op_valid_q;
        op_count_d   = op_count_q;

        if (bus.clear) begin
            state_d    = S_A;
            op_valid_d = 1'b0;
            a_d        = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (in_xfer) begin
                        a_d     = bus.din;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (in_xfer) begin
                        op_a_d       = do_swap ? bus.din : a_q;
                        op_b_d       = do_swap ? a_q : bus.din;
                        op_swapped_d = do_swap;
                        op_bin_d     = bus.bin_in;
                        op_valid_d   = 1'b1;
                        state_d      = S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_xfer) begin
                        op_count_d = op_count_q + 1'b1;
                        op_valid_d = 1'b0;
                        if (in_xfer) begin
                            a_d     = bus.din;
                            state_d = S_B;
                        end else begin
                            state_d = S_A;
                        end
                    end
                end
                default: begin
                    state_d    = S_A;
                    op_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_A;
            a_q          <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_bin_q     <= 1'b0;
            op_swapped_q <= 1'b0;
            op_valid_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_bin_q     <= op_bin_d;
            op_swapped_q <= op_swapped_d;
            op_valid_q   <= op_valid_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.op_bin     = op_bin_q;
    assign bus.op_swapped = op_swapped_q;
    assign bus.op_valid   = op_valid_q;
    assign bus.op_count   = op_count_q;
endmodule
`default_nettype wire
